// File: rtl/serie_paralelo_pkg.sv
// Shared types and constants for the serial-to-parallel comma aligner.
package serie_paralelo_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] DEF_COM_SYM = 8'hBC;
  localparam logic [7:0] DEF_IDL_SYM = 8'h7C;

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serie_paralelo_lock_fsm.sv
// Comma lock tracker: hunts for COM, confirms LOCK_COUNT aligned COMs,
// and drops lock after MAX_GAP consecutive non-COM symbols.
module serie_paralelo_lock_fsm
  import serie_paralelo_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int MAX_GAP    = 64
) (
  input  logic   clk32f,
  input  logic   reset,
  input  logic   boundary,
  input  logic   is_com,
  output state_t state,
  output state_t state_nxt,
  output logic   force_unlock
);

  localparam int CW = clog2w(LOCK_COUNT + 1);
  localparam int GW = clog2w(MAX_GAP + 1);
  localparam logic [CW-1:0] LOCK_C = CW'(LOCK_COUNT);
  localparam logic [GW-1:0] GAP_C  = GW'(MAX_GAP);

  logic [CW-1:0] com_cnt, com_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt;

  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      state   <= HUNT;
      com_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      com_cnt <= com_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    com_nxt      = com_cnt;
    gap_nxt      = gap_cnt;
    force_unlock = 1'b0;
    case (state)
      HUNT: begin
        // Any bit offset is accepted; the COM found here is the first counted one.
        if (is_com) begin
          com_nxt = CW'(1);
          if (LOCK_COUNT == 1) begin
            state_nxt = LOCKED;
            gap_nxt   = '0;
          end else begin
            state_nxt = CHECK;
          end
        end
      end
      CHECK: begin
        if (boundary) begin
          if (is_com) begin
            com_nxt = com_cnt + CW'(1);
            if (com_nxt == LOCK_C) begin
              state_nxt = LOCKED;
              gap_nxt   = '0;
            end
          end else begin
            state_nxt = HUNT;
            com_nxt   = '0;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          if (is_com) begin
            gap_nxt = '0;
          end else begin
            gap_nxt = gap_cnt + GW'(1);
            if (gap_nxt == GAP_C) begin
              state_nxt    = HUNT;
              com_nxt      = '0;
              force_unlock = 1'b1;
            end
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

endmodule

// File: rtl/serie_paralelo_sync.sv
// Single-clock serial-to-parallel converter with comma alignment, lock
// tracking and a self-generated symbol strobe.
module serie_paralelo_sync
  import serie_paralelo_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COM_SYM    = WIDTH'(DEF_COM_SYM),
  parameter logic [WIDTH-1:0] IDL_SYM    = WIDTH'(DEF_IDL_SYM),
  parameter int               LOCK_COUNT = 4,
  parameter int               MAX_GAP    = 64
) (
  input  logic             clk32f,
  input  logic             reset,
  input  logic             in,
  output logic [WIDTH-1:0] data_out,
  output logic             valido,
  output logic             idle,
  output logic             active,
  output logic             sym_stb
);

  localparam int PW = clog2w(WIDTH);
  localparam logic [PW-1:0] PH_LAST = PW'(WIDTH - 1);

  logic [WIDTH-1:0] sr;
  logic [PW-1:0]    phase;
  state_t           state, state_nxt;
  logic             force_unlock;
  logic             is_com, is_idl, boundary, upd;

  assign is_com   = (sr == COM_SYM);
  assign is_idl   = (sr == IDL_SYM);
  assign boundary = (phase == '0) || (state == HUNT && is_com);
  // The COM that completes the lock is itself presented, so active and the
  // first strobe rise together.
  assign upd      = boundary && (state == LOCKED || state_nxt == LOCKED);

  serie_paralelo_lock_fsm #(
    .LOCK_COUNT(LOCK_COUNT),
    .MAX_GAP   (MAX_GAP)
  ) u_fsm (
    .clk32f      (clk32f),
    .reset       (reset),
    .boundary    (boundary),
    .is_com      (is_com),
    .state       (state),
    .state_nxt   (state_nxt),
    .force_unlock(force_unlock)
  );

  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      sr       <= '0;
      phase    <= '0;
      data_out <= '0;
      valido   <= 1'b0;
      idle     <= 1'b0;
      active   <= 1'b0;
      sym_stb  <= 1'b0;
    end else begin
      sr <= {sr[WIDTH-2:0], in};
      if (state == HUNT && is_com)
        phase <= PW'(1);
      else if (phase == PH_LAST)
        phase <= '0;
      else
        phase <= phase + PW'(1);
      active  <= (state_nxt == LOCKED);
      sym_stb <= upd;
      if (upd) begin
        data_out <= sr;
        idle     <= is_idl && !force_unlock;
        valido   <= !is_com && !is_idl && !force_unlock;
      end else if (state_nxt != LOCKED) begin
        idle   <= 1'b0;
        valido <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serie_paralelo_sync.sv
// Directed bench for serie_paralelo_sync: a symbol-level model checked every
// cycle, plus literal expectations on the logged strobe sequence.
module tb_serie_paralelo_sync;

  logic clk32f = 1'b0;
  always #5 clk32f = ~clk32f;

  logic       rst8 = 1'b0, in8 = 1'b0;
  logic [7:0] d8;
  logic       v8, i8, a8, s8;
  logic       rst10 = 1'b0, in10 = 1'b0;
  logic [9:0] d10;
  logic       v10, i10, a10, s10;

  serie_paralelo_sync dut8 (
    .clk32f(clk32f), .reset(rst8), .in(in8), .data_out(d8),
    .valido(v8), .idle(i8), .active(a8), .sym_stb(s8));

  serie_paralelo_sync #(
    .WIDTH(10), .COM_SYM(10'h17C), .IDL_SYM(10'h07C), .LOCK_COUNT(2), .MAX_GAP(64)
  ) dut10 (
    .clk32f(clk32f), .reset(rst10), .in(in10), .data_out(d10),
    .valido(v10), .idle(i10), .active(a10), .sym_stb(s10));

  // ---------------- behavioural model ----------------
  typedef struct {
    int win;      // last w received bits
    int since;    // bits since the current alignment point, mod w
    bit hunting;
    bit locked;
    int hits;
    int gap;
    int data;
    bit v, i, a, s;
  } mdl_t;

  function automatic mdl_t mreset();
    mdl_t r;
    r.win = 0; r.since = 0; r.hunting = 1; r.locked = 0; r.hits = 0; r.gap = 0;
    r.data = 0; r.v = 0; r.i = 0; r.a = 0; r.s = 0;
    return r;
  endfunction

  function automatic mdl_t mstep(mdl_t c, bit b, int w, int com_s, int idl_s, int lc, int mg);
    mdl_t n;
    bit com, idl, at_sym, drop;
    n      = c;
    com    = (c.win == com_s);
    idl    = (c.win == idl_s);
    at_sym = (c.since == 0) || (c.hunting && com);
    drop   = 0;
    n.s    = 0;
    n.since = (c.since + 1) % w;
    if (c.hunting) begin
      if (com) begin
        n.since = 1; n.hits = 1; n.hunting = 0;
        if (lc == 1) begin n.locked = 1; n.gap = 0; end
      end
    end else if (!c.locked) begin
      if (at_sym) begin
        if (com) begin
          n.hits = c.hits + 1;
          if (n.hits == lc) begin n.locked = 1; n.gap = 0; end
        end else begin
          n.hunting = 1; n.hits = 0;
        end
      end
    end else if (at_sym) begin
      if (com) n.gap = 0;
      else begin
        n.gap = c.gap + 1;
        if (n.gap == mg) begin drop = 1; n.locked = 0; n.hunting = 1; n.hits = 0; end
      end
    end
    if (at_sym && (c.locked || n.locked)) begin
      n.data = c.win;
      n.v = !com && !idl && !drop;
      n.i = idl && !drop;
      n.s = 1;
    end else if (!n.locked) begin
      n.v = 0; n.i = 0;
    end
    n.a   = n.locked;
    n.win = ((c.win << 1) | int'(b)) & ((1 << w) - 1);
    return n;
  endfunction

  mdl_t m8, m10;
  always @(posedge clk32f or negedge rst8)
    if (!rst8) m8 <= mreset();
    else       m8 <= mstep(m8, in8, 8, 'hBC, 'h7C, 4, 64);
  always @(posedge clk32f or negedge rst10)
    if (!rst10) m10 <= mreset();
    else        m10 <= mstep(m10, in10, 10, 'h17C, 'h07C, 2, 64);

  int cyc = 0;
  always @(posedge clk32f) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  int tests = 0, fails = 0;

  typedef struct { int cyc; int data; bit v, i, a; } ev_t;
  ev_t log8[$], log10[$];
  int  rise8 = -1, rise10 = -1;

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic int outs(int d, bit v, bit i, bit a, bit s);
    return (d << 4) | (int'(v) << 3) | (int'(i) << 2) | (int'(a) << 1) | int'(s);
  endfunction

  function automatic int mk(int d, bit v, bit i, bit a);
    return (d << 3) | (int'(v) << 2) | (int'(i) << 1) | int'(a);
  endfunction

  function automatic ev_t ev_at(input ev_t q[$], input int k);
    ev_t e;
    e.cyc = -1; e.data = -1; e.v = 0; e.i = 0; e.a = 0;
    if (k < q.size()) e = q[k];
    return e;
  endfunction

  function automatic int pk(ev_t e);
    return mk(e.data, e.v, e.i, e.a);
  endfunction

  // ---------------- stimulus ----------------
  task automatic bit8(input bit b);
    in8 = b; @(posedge clk32f); #1;
  endtask
  task automatic sym8(input int v);
    for (int j = 7; j >= 0; j--) bit8(v[j]);
  endtask
  task automatic bit10(input bit b);
    in10 = b; @(posedge clk32f); #1;
  endtask
  task automatic sym10(input int v);
    for (int j = 9; j >= 0; j--) bit10(v[j]);
  endtask
  task automatic pulse8();
    rst8 = 1'b0; in8 = 1'b0;
    repeat (2) @(posedge clk32f);
    #1 rst8 = 1'b1;
    log8.delete(); rise8 = -1;
  endtask

  int   t;
  ev_t  e0, e1, e2, e3;
  logic [7:0] com8 = 8'hBC;
  logic [6:0] junk10 = 7'b1100101;

  initial begin
    fork
      begin : compare
        bit pa8, pa10;
        pa8 = 0; pa10 = 0;
        forever begin
          @(negedge clk32f);
          chk($sformatf("model8@%0d", cyc), outs(int'(d8), v8, i8, a8, s8),
              outs(m8.data, m8.v, m8.i, m8.a, m8.s));
          chk($sformatf("model10@%0d", cyc), outs(int'(d10), v10, i10, a10, s10),
              outs(m10.data, m10.v, m10.i, m10.a, m10.s));
          if (s8)  log8.push_back('{cyc, int'(d8), v8, i8, a8});
          if (s10) log10.push_back('{cyc, int'(d10), v10, i10, a10});
          if (a8 && !pa8)   rise8 = cyc;
          if (a10 && !pa10) rise10 = cyc;
          pa8 = a8; pa10 = a10;
        end
      end
    join_none

    // Reset held with toggling input
    repeat (10) begin in8 = ~in8; in10 = ~in10; @(posedge clk32f); #1; end
    chk("rst_outs", outs(int'(d8), v8, i8, a8, s8), 0);
    rst8 = 1'b1; in8 = 1'b0;
    repeat (3) @(posedge clk32f);
    #1;
    chk("post_rst_outs", outs(int'(d8), v8, i8, a8, s8), 0);
    chk("post_rst_state", int'(dut8.u_fsm.state), 0);

    // 3 junk bits, 4 COMs, IDLE, data
    log8.delete(); rise8 = -1;
    bit8(0); bit8(1); bit8(0);
    repeat (4) sym8('hBC);
    t = cyc;
    sym8('h7C); sym8('h55); sym8('h00);
    e0 = ev_at(log8, 0); e1 = ev_at(log8, 1); e2 = ev_at(log8, 2);
    chk("s1_nstb", log8.size(), 3);
    chk("s1_lock_sym", pk(e0), mk('hBC, 0, 0, 1));
    chk("s1_latency", e0.cyc - t, 1);
    chk("s1_active_rise", rise8, e0.cyc);
    chk("s1_idle_sym", pk(e1), mk('h7C, 0, 1, 1));
    chk("s1_period", e1.cyc - e0.cyc, 8);
    chk("s1_data_sym", pk(e2), mk('h55, 1, 0, 1));

    // Broken COM run falls back to HUNT, then relocks
    pulse8();
    repeat (2) sym8('hBC);
    sym8('h12);
    bit8(com8[7]);
    chk("s2_hunt_state", int'(dut8.u_fsm.state), 0);
    chk("s2_nolock", log8.size() + int'(a8), 0);
    for (int j = 6; j >= 0; j--) bit8(com8[j]);
    repeat (3) sym8('hBC);
    t = cyc;
    sym8('h55);
    e0 = ev_at(log8, 0);
    chk("s2_nstb", log8.size(), 1);
    chk("s2_lock_sym", pk(e0), mk('hBC, 0, 0, 1));
    chk("s2_latency", e0.cyc - t, 1);

    // 64 non-COM symbols drop lock
    pulse8();
    repeat (4) sym8('hBC);
    repeat (64) sym8('h55);
    repeat (3) sym8('h55);
    chk("s3_nstb", log8.size(), 65);
    chk("s3_sym63", pk(ev_at(log8, 63)), mk('h55, 1, 0, 1));
    chk("s3_sym64_drop", pk(ev_at(log8, 64)), mk('h55, 0, 0, 0));
    chk("s3_active_now", int'(a8), 0);

    // A COM at symbol 63 keeps lock
    pulse8();
    repeat (4) sym8('hBC);
    repeat (62) sym8('h55);
    sym8('hBC);
    repeat (11) sym8('h55);
    chk("s3b_nstb", log8.size(), 74);
    chk("s3b_com63", pk(ev_at(log8, 63)), mk('hBC, 0, 0, 1));
    chk("s3b_last", pk(ev_at(log8, 73)), mk('h55, 1, 0, 1));
    chk("s3b_active_now", int'(a8), 1);

    // Asynchronous reset mid-symbol, then full reacquisition
    pulse8();
    repeat (4) sym8('hBC);
    sym8('h55); sym8('h55);
    bit8(0); bit8(1); bit8(0);
    #2 rst8 = 1'b0;
    #1 chk("s4_async_zero", outs(int'(d8), v8, i8, a8, s8), 0);
    @(posedge clk32f);
    #3 rst8 = 1'b1;
    log8.delete(); rise8 = -1;
    bit8(1); bit8(0); bit8(1); bit8(0); bit8(1);
    repeat (3) sym8('hBC);
    sym8('h55);
    chk("s4_no_lock_3com", log8.size() + int'(a8), 0);
    repeat (4) sym8('hBC);
    t = cyc;
    sym8('h55);
    e0 = ev_at(log8, 0);
    chk("s4_relock_sym", pk(e0), mk('hBC, 0, 0, 1));
    chk("s4_relock_latency", e0.cyc - t, 1);

    // 10-bit instance, offset 7, LOCK_COUNT=2
    rst8 = 1'b0;
    rst10 = 1'b1;
    log10.delete(); rise10 = -1;
    for (int j = 6; j >= 0; j--) bit10(junk10[j]);
    repeat (2) sym10('h17C);
    t = cyc;
    sym10('h2A5); sym10('h07C); sym10('h155); sym10('h000);
    e0 = ev_at(log10, 0); e1 = ev_at(log10, 1); e2 = ev_at(log10, 2); e3 = ev_at(log10, 3);
    chk("s5_nstb", log10.size(), 4);
    chk("s5_lock_sym", pk(e0), mk('h17C, 0, 0, 1));
    chk("s5_latency", e0.cyc - t, 1);
    chk("s5_active_rise", rise10, e0.cyc);
    chk("s5_data1", pk(e1), mk('h2A5, 1, 0, 1));
    chk("s5_idle", pk(e2), mk('h07C, 0, 1, 1));
    chk("s5_data2", pk(e3), mk('h155, 1, 0, 1));
    chk("s5_period_a", e1.cyc - e0.cyc, 10);
    chk("s5_period_b", e3.cyc - e2.cyc, 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
